// File: rtl/dma_if_pkg.sv
// dma_if_pkg: shared arbitration mode encodings and port-index width helper for DMA request muxes
//   arb_mode_t : ARB_FIXED (lowest index wins) / ARB_RR (round robin)
//   cl_ports() : port-index width, never narrower than one bit
package dma_if_pkg;
   typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
   function automatic int cl_ports(input int ports);
      return ports > 1 ? $clog2(ports) : 1;
   endfunction
endpackage

// File: rtl/dma_read_req_arb_mux_if.sv
// dma_read_req_arb_mux_if: request-side (packed per-port slices) and merged-side DMA read descriptor bus
//   s_axis_dma_read_desc_* : PORTS packed descriptors with per-port valid/ready
//   m_axis_dma_read_desc_* : single merged descriptor, tag widened by the port index
//   slave  : arbiter view, master : source/sink view
interface dma_read_req_arb_mux_if
   import dma_if_pkg::*;
#(
   parameter int PORTS = 2,
   parameter int RAM_ADDR_WIDTH = 16,
   parameter int DMA_ADDR_WIDTH = 64,
   parameter int DMA_LEN_WIDTH = 20,
   parameter int DMA_TAG_WIDTH = 10
);
   localparam int CL_PORTS = cl_ports(PORTS);
   logic [PORTS*DMA_ADDR_WIDTH-1:0] s_axis_dma_read_desc_dma_addr;
   logic [PORTS*RAM_ADDR_WIDTH-1:0] s_axis_dma_read_desc_ram_addr;
   logic [PORTS*DMA_LEN_WIDTH-1:0] s_axis_dma_read_desc_len;
   logic [PORTS*DMA_TAG_WIDTH-1:0] s_axis_dma_read_desc_tag;
   logic [PORTS-1:0] s_axis_dma_read_desc_valid;
   logic [PORTS-1:0] s_axis_dma_read_desc_ready;
   logic [DMA_ADDR_WIDTH-1:0] m_axis_dma_read_desc_dma_addr;
   logic [RAM_ADDR_WIDTH-1:0] m_axis_dma_read_desc_ram_addr;
   logic [DMA_LEN_WIDTH-1:0] m_axis_dma_read_desc_len;
   logic [DMA_TAG_WIDTH+CL_PORTS-1:0] m_axis_dma_read_desc_tag;
   logic m_axis_dma_read_desc_valid;
   logic m_axis_dma_read_desc_ready;
   modport slave (
      input s_axis_dma_read_desc_dma_addr, s_axis_dma_read_desc_ram_addr, s_axis_dma_read_desc_len,
      input s_axis_dma_read_desc_tag, s_axis_dma_read_desc_valid,
      output s_axis_dma_read_desc_ready,
      output m_axis_dma_read_desc_dma_addr, m_axis_dma_read_desc_ram_addr, m_axis_dma_read_desc_len,
      output m_axis_dma_read_desc_tag, m_axis_dma_read_desc_valid,
      input m_axis_dma_read_desc_ready
   );
   modport master (
      output s_axis_dma_read_desc_dma_addr, s_axis_dma_read_desc_ram_addr, s_axis_dma_read_desc_len,
      output s_axis_dma_read_desc_tag, s_axis_dma_read_desc_valid,
      input s_axis_dma_read_desc_ready,
      input m_axis_dma_read_desc_dma_addr, m_axis_dma_read_desc_ram_addr, m_axis_dma_read_desc_len,
      input m_axis_dma_read_desc_tag, m_axis_dma_read_desc_valid,
      output m_axis_dma_read_desc_ready
   );
endinterface

// File: rtl/dma_req_rr_arbiter.sv
// dma_req_rr_arbiter: combinational fixed-priority / round-robin request arbiter
//   req    : per-port request vector
//   rr_ptr : round-robin search start (ignored in fixed mode)
//   mode   : ARB_FIXED or ARB_RR
//   grant  : one-hot grant, idx : encoded grant, vld : any request present
module dma_req_rr_arbiter
   import dma_if_pkg::*;
#(
   parameter int PORTS = 2,
   parameter int CL_PORTS = cl_ports(PORTS)
)
(
   input  logic [PORTS-1:0] req,
   input  logic [CL_PORTS-1:0] rr_ptr,
   input  arb_mode_t mode,
   output logic [PORTS-1:0] grant,
   output logic [CL_PORTS-1:0] idx,
   output logic vld
);
   logic [CL_PORTS-1:0] start;
   assign start = mode == ARB_RR ? rr_ptr : '0;
   assign vld = |req;
   // Scan from the farthest offset back to start so the nearest requester wins last.
   always_comb begin
      idx = '0;
      for (int k = PORTS - 1; k >= 0; k--)
         if (req[(k + int'(start)) % PORTS]) idx = CL_PORTS'((k + int'(start)) % PORTS);
   end
   always_comb begin
      grant = '0;
      grant[idx] = vld;
   end
endmodule

// File: rtl/dma_read_req_arb_mux.sv
// dma_read_req_arb_mux: N-port DMA read-request arbiter with registered output, port index prepended to tag
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request slices in, merged registered descriptor out (AXI-stream hold rule)
module dma_read_req_arb_mux
   import dma_if_pkg::*;
#(
   parameter int PORTS = 2,
   parameter int RAM_ADDR_WIDTH = 16,
   parameter int DMA_ADDR_WIDTH = 64,
   parameter int DMA_LEN_WIDTH = 20,
   parameter int DMA_TAG_WIDTH = 10,
   parameter int ARB_ROUND_ROBIN = 0
)
(
   input logic clk,
   input logic rst,
   dma_read_req_arb_mux_if.slave bus
);
   localparam int CL_PORTS = cl_ports(PORTS);
   localparam arb_mode_t MODE = ARB_ROUND_ROBIN != 0 ? ARB_RR : ARB_FIXED;
   logic load_en, vld;
   logic [PORTS-1:0] req, grant;
   logic [CL_PORTS-1:0] idx, rr_ptr;
   assign load_en = !bus.m_axis_dma_read_desc_valid || bus.m_axis_dma_read_desc_ready;
   // Masking requests during reset keeps every ready low, so no handshake completes then.
   assign req = bus.s_axis_dma_read_desc_valid & {PORTS{load_en && !rst}};
   assign bus.s_axis_dma_read_desc_ready = grant;
   dma_req_rr_arbiter #(.PORTS(PORTS), .CL_PORTS(CL_PORTS)) u_arb (
      .req(req),
      .rr_ptr(rr_ptr),
      .mode(MODE),
      .grant(grant),
      .idx(idx),
      .vld(vld)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.m_axis_dma_read_desc_dma_addr <= '0;
         bus.m_axis_dma_read_desc_ram_addr <= '0;
         bus.m_axis_dma_read_desc_len <= '0;
         bus.m_axis_dma_read_desc_tag <= '0;
         bus.m_axis_dma_read_desc_valid <= 1'b0;
         rr_ptr <= '0;
      end else if (vld) begin
         bus.m_axis_dma_read_desc_dma_addr <= bus.s_axis_dma_read_desc_dma_addr[int'(idx)*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
         bus.m_axis_dma_read_desc_ram_addr <= bus.s_axis_dma_read_desc_ram_addr[int'(idx)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
         bus.m_axis_dma_read_desc_len <= bus.s_axis_dma_read_desc_len[int'(idx)*DMA_LEN_WIDTH +: DMA_LEN_WIDTH];
         bus.m_axis_dma_read_desc_tag <= {idx, bus.s_axis_dma_read_desc_tag[int'(idx)*DMA_TAG_WIDTH +: DMA_TAG_WIDTH]};
         bus.m_axis_dma_read_desc_valid <= 1'b1;
         if (MODE == ARB_RR) rr_ptr <= CL_PORTS'((int'(idx) + 1) % PORTS);
      end else if (load_en) begin
         bus.m_axis_dma_read_desc_valid <= 1'b0;
      end
endmodule

// File: tb/tb_dma_read_req_arb_mux.sv
// tb_dma_read_req_arb_mux: table-driven and scoreboard bench for fixed (2-port) and round-robin (4-port) muxes
module tb_dma_read_req_arb_mux;
   import dma_if_pkg::*;
   typedef struct {logic [63:0] dma; logic [15:0] ram; logic [19:0] len; logic [11:0] tag;} desc_t;
   typedef struct {logic [3:0] v; logic r; logic [3:0] er;} vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dma_read_req_arb_mux_if #(.PORTS(2)) fi();
   dma_read_req_arb_mux_if #(.PORTS(4)) ri();
   dma_read_req_arb_mux #(.PORTS(2), .ARB_ROUND_ROBIN(0)) u_fix (.clk(clk), .rst(rst), .bus(fi.slave));
   dma_read_req_arb_mux #(.PORTS(4), .ARB_ROUND_ROBIN(1)) u_rr (.clk(clk), .rst(rst), .bus(ri.slave));
   int passed = 0;
   int total = 0;
   int f_seq = 0;
   int r_seq = 0;
   desc_t fq[$];
   desc_t rq[$];
   desc_t f_last, r_last, zero_d;
   vec_t ft[12];
   vec_t rt[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Output-form descriptor of port p in sequence step seq; tag already carries the port index.
   function automatic desc_t gen(input int p, input int seq);
      desc_t d;
      d.dma = 64'h1000 | (64'(seq) << 20);
      d.ram = 16'(seq * 16 + p);
      d.len = 20'(seq * 256 + p + 1);
      d.tag = 12'((p << 10) | ((seq % 256) * 4 + p));
      return d;
   endfunction

   function automatic int oh_idx(input logic [3:0] er);
      for (int i = 0; i < 4; i++) if (er[i]) return i;
      return 0;
   endfunction

   task automatic drive_f();
      desc_t d;
      for (int p = 0; p < 2; p++) begin
         d = gen(p, f_seq);
         fi.s_axis_dma_read_desc_dma_addr[p*64 +: 64] = d.dma;
         fi.s_axis_dma_read_desc_ram_addr[p*16 +: 16] = d.ram;
         fi.s_axis_dma_read_desc_len[p*20 +: 20] = d.len;
         fi.s_axis_dma_read_desc_tag[p*10 +: 10] = d.tag[9:0];
      end
   endtask

   task automatic drive_r();
      desc_t d;
      for (int p = 0; p < 4; p++) begin
         d = gen(p, r_seq);
         ri.s_axis_dma_read_desc_dma_addr[p*64 +: 64] = d.dma;
         ri.s_axis_dma_read_desc_ram_addr[p*16 +: 16] = d.ram;
         ri.s_axis_dma_read_desc_len[p*20 +: 20] = d.len;
         ri.s_axis_dma_read_desc_tag[p*10 +: 10] = d.tag[9:0];
      end
   endtask

   task automatic f_out_chk();
      desc_t e;
      e = f_last;
      if (fq.size() != 0) e = fq[0];
      chk("f_m_valid", 64'(fi.m_axis_dma_read_desc_valid), 64'(fq.size() != 0));
      chk("f_dma_addr", fi.m_axis_dma_read_desc_dma_addr, e.dma);
      chk("f_ram_addr", 64'(fi.m_axis_dma_read_desc_ram_addr), 64'(e.ram));
      chk("f_len", 64'(fi.m_axis_dma_read_desc_len), 64'(e.len));
      chk("f_tag", 64'(fi.m_axis_dma_read_desc_tag), 64'(e.tag));
   endtask

   task automatic r_out_chk();
      desc_t e;
      e = r_last;
      if (rq.size() != 0) e = rq[0];
      chk("r_m_valid", 64'(ri.m_axis_dma_read_desc_valid), 64'(rq.size() != 0));
      chk("r_dma_addr", ri.m_axis_dma_read_desc_dma_addr, e.dma);
      chk("r_ram_addr", 64'(ri.m_axis_dma_read_desc_ram_addr), 64'(e.ram));
      chk("r_len", 64'(ri.m_axis_dma_read_desc_len), 64'(e.len));
      chk("r_tag", 64'(ri.m_axis_dma_read_desc_tag), 64'(e.tag));
   endtask

   // One cycle: drive, check ready and output mid-cycle, then model the clock edge in the scoreboard.
   task automatic f_step(input logic [1:0] v, input logic r, input logic [1:0] er);
      f_seq++;
      drive_f();
      fi.s_axis_dma_read_desc_valid = v;
      fi.m_axis_dma_read_desc_ready = r;
      @(negedge clk);
      chk("f_s_ready", 64'(fi.s_axis_dma_read_desc_ready), 64'(er));
      f_out_chk();
      if (fq.size() != 0 && r) f_last = fq.pop_front();
      if (er != 0) fq.push_back(gen(oh_idx({2'b00, er}), f_seq));
      @(posedge clk);
      #1;
   endtask

   task automatic r_step(input logic [3:0] v, input logic r, input logic [3:0] er);
      r_seq++;
      drive_r();
      ri.s_axis_dma_read_desc_valid = v;
      ri.m_axis_dma_read_desc_ready = r;
      @(negedge clk);
      chk("r_s_ready", 64'(ri.s_axis_dma_read_desc_ready), 64'(er));
      r_out_chk();
      if (rq.size() != 0 && r) r_last = rq.pop_front();
      if (er != 0) rq.push_back(gen(oh_idx(er), r_seq));
      @(posedge clk);
      #1;
   endtask

   initial begin
      zero_d = '{dma: '0, ram: '0, len: '0, tag: '0};
      f_last = zero_d;
      r_last = zero_d;
      drive_f();
      drive_r();
      fi.s_axis_dma_read_desc_valid = 2'b11;
      ri.s_axis_dma_read_desc_valid = 4'hF;
      fi.m_axis_dma_read_desc_ready = 1'b1;
      ri.m_axis_dma_read_desc_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_f_s_ready", 64'(fi.s_axis_dma_read_desc_ready), 64'd0);
      chk("rst_r_s_ready", 64'(ri.s_axis_dma_read_desc_ready), 64'd0);
      f_out_chk();
      r_out_chk();
      @(posedge clk);
      #1;
      rst = 1'b0;
      fi.s_axis_dma_read_desc_valid = '0;
      ri.s_axis_dma_read_desc_valid = '0;
      ft = '{
         '{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0001},
         '{4'b0011, 1'b1, 4'b0001}, '{4'b0010, 1'b1, 4'b0010}, '{4'b0000, 1'b1, 4'b0000},
         '{4'b0000, 1'b1, 4'b0000}, '{4'b0001, 1'b0, 4'b0001}, '{4'b0011, 1'b0, 4'b0000},
         '{4'b0011, 1'b1, 4'b0001}, '{4'b0000, 1'b1, 4'b0000}, '{4'b0000, 1'b0, 4'b0000}
      };
      rt = '{
         '{4'b1111, 1'b1, 4'b0001}, '{4'b1111, 1'b1, 4'b0010}, '{4'b1111, 1'b1, 4'b0100},
         '{4'b1111, 1'b1, 4'b1000}, '{4'b1111, 1'b1, 4'b0001}, '{4'b1111, 1'b1, 4'b0010},
         '{4'b0000, 1'b1, 4'b0000}, '{4'b0000, 1'b1, 4'b0000}, '{4'b0100, 1'b1, 4'b0100},
         '{4'b1010, 1'b1, 4'b1000}, '{4'b1010, 1'b1, 4'b0010}, '{4'b0000, 1'b1, 4'b0000}
      };
      for (int i = 0; i < 12; i++) f_step(ft[i].v[1:0], ft[i].r, ft[i].er[1:0]);
      for (int i = 0; i < 12; i++) r_step(rt[i].v, rt[i].r, rt[i].er);
      // Backpressure: port 1 loads dma_addr 0x1000 / tag 0x401, then five stalled cycles.
      r_seq = -1;
      r_step(4'b0010, 1'b1, 4'b0010);
      for (int i = 0; i < 5; i++) r_step(4'b1111, 1'b0, 4'b0000);
      chk("bp_tag", 64'(ri.m_axis_dma_read_desc_tag), 64'h401);
      chk("bp_dma_addr", ri.m_axis_dma_read_desc_dma_addr, 64'h1000);
      r_step(4'b1111, 1'b1, 4'b0100);
      r_step(4'b1111, 1'b0, 4'b0000);
      // Async reset mid-stall with the output register full.
      rst = 1'b1;
      #2;
      chk("arst_m_valid", 64'(ri.m_axis_dma_read_desc_valid), 64'd0);
      chk("arst_s_ready", 64'(ri.s_axis_dma_read_desc_ready), 64'd0);
      rq.delete();
      fq.delete();
      r_last = zero_d;
      f_last = zero_d;
      r_out_chk();
      f_out_chk();
      @(posedge clk);
      #1;
      rst = 1'b0;
      r_step(4'b1111, 1'b1, 4'b0001);
      r_step(4'b0000, 1'b1, 4'b0000);
      r_step(4'b0000, 1'b1, 4'b0000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
